// File: rtl/ena_scheduler.sv
// Gate-enable scheduler: picks at most one excited gate per cycle (round-robin,
// fixed priority or LFSR), forces long-waiting gates, tracks quiescence and fires.
module ena_scheduler #(
  parameter int N        = 8,
  parameter int MAX_WAIT = 15,
  parameter int QUIET    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [1:0]   mode,
  input  logic [N-1:0] excited,
  output logic [N-1:0] ena,
  output logic         starved,
  output logic         quiescent,
  output logic [15:0]  fire_count
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [7:0]    lfsr;
  logic [3:0]    wait_cnt [N];
  logic [3:0]    q_cnt;

  logic [IW-1:0] start_idx;
  logic [IW-1:0] cand;
  logic [IW-1:0] sel_idx;
  logic          sel_ok;
  logic [IW-1:0] st_idx;
  logic          st_ok;
  logic [IW-1:0] grant_idx;
  logic          grant_ok;
  logic [N-1:0]  grant_vec;
  logic [3:0]    q_next;
  logic          lfsr_fb;

  always_comb begin
    case (mode)
      2'd1:    start_idx = '0;
      2'd2:    start_idx = lfsr[IW-1:0];
      default: start_idx = ptr;
    endcase

    // Loops run downward so the lowest offset / lowest index is the last writer.
    sel_idx = '0;
    sel_ok  = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start_idx + IW'(k);
      if (excited[cand]) begin
        sel_idx = cand;
        sel_ok  = 1'b1;
      end
    end

    st_idx = '0;
    st_ok  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (excited[i] && (wait_cnt[i] >= 4'(MAX_WAIT))) begin
        st_idx = IW'(i);
        st_ok  = 1'b1;
      end
    end

    grant_ok  = run && (st_ok || sel_ok);
    grant_idx = st_ok ? st_idx : sel_idx;
    grant_vec = grant_ok ? (N'(1) << grant_idx) : '0;

    if (!run)
      q_next = q_cnt;
    else if (excited != '0)
      q_next = '0;
    else if (q_cnt == 4'hF)
      q_next = q_cnt;
    else
      q_next = q_cnt + 4'd1;

    lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ena        <= '0;
      starved    <= 1'b0;
      quiescent  <= 1'b0;
      fire_count <= '0;
      ptr        <= '0;
      lfsr       <= 8'h01;
      q_cnt      <= '0;
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      if ((ena != '0) && (fire_count != 16'hFFFF))
        fire_count <= fire_count + 16'd1;

      ena       <= grant_vec;
      starved   <= grant_ok && st_ok;
      q_cnt     <= q_next;
      quiescent <= (q_next >= 4'(QUIET));

      if (run) begin
        lfsr <= {lfsr[6:0], lfsr_fb};
        if (grant_ok) ptr <= grant_idx + IW'(1);
        for (int i = 0; i < N; i++) begin
          if (!excited[i] || grant_vec[i])
            wait_cnt[i] <= '0;
          else if (wait_cnt[i] != 4'hF)
            wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end
      end
    end
  end

endmodule
